// File: rtl/tracker_pkg.sv
// Shared types and helpers for the marker tracker: FSM states, bus width
// derivations and the unsigned distance primitive used by the matcher.
package tracker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MATCH,
    FILL,
    UPDATE,
    DONE
  } state_t;

  // Common working width for distance and smoothing arithmetic; wide enough
  // for any supported screen dimension plus headroom.
  localparam int CW = 16;

  function automatic int calc_xw(input int screen_width);
    return $clog2(screen_width);
  endfunction

  function automatic int calc_yw(input int screen_height);
    return $clog2(screen_height) + 1;
  endfunction

  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/target_tracker_wrapper_if.sv
// Raster position, raw detections and smoothed tracks exchanged between
// get_target (master side) and the tracker (slave side).
interface target_tracker_wrapper_if #(
  parameter int NUM_TARGETS   = 4,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720
) ();

  localparam int XW = tracker_pkg::calc_xw(SCREEN_WIDTH);
  localparam int YW = tracker_pkg::calc_yw(SCREEN_HEIGHT);

  logic [XW-1:0]             hcount_in;
  logic [YW-1:0]             vcount_in;
  logic [NUM_TARGETS*XW-1:0] det_x_in;
  logic [NUM_TARGETS*YW-1:0] det_y_in;
  logic [NUM_TARGETS*YW-1:0] det_d_in;
  logic [NUM_TARGETS-1:0]    det_valid_in;
  logic [NUM_TARGETS*XW-1:0] trk_x_out;
  logic [NUM_TARGETS*YW-1:0] trk_y_out;
  logic [NUM_TARGETS*YW-1:0] trk_d_out;
  logic [NUM_TARGETS-1:0]    trk_valid_out;
  logic                      frame_done_out;
  logic                      frame_drop_out;

  modport master (
    output hcount_in, vcount_in, det_x_in, det_y_in, det_d_in, det_valid_in,
    input  trk_x_out, trk_y_out, trk_d_out, trk_valid_out, frame_done_out, frame_drop_out
  );

  modport slave (
    input  hcount_in, vcount_in, det_x_in, det_y_in, det_d_in, det_valid_in,
    output trk_x_out, trk_y_out, trk_d_out, trk_valid_out, frame_done_out, frame_drop_out
  );

endinterface

// File: rtl/track_slot_update.sv
// Next-state datapath for one track slot: smooths a matched track toward its
// detection (clamped to the screen) or ages an unmatched one until it drops.
module track_slot_update #(
  parameter int XW            = 11,
  parameter int YW            = 11,
  parameter int MW            = 2,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int ALPHA_SHIFT   = 2,
  parameter int MAX_MISS      = 3
) (
  input  logic [XW-1:0] i_trk_x,
  input  logic [YW-1:0] i_trk_y,
  input  logic [YW-1:0] i_trk_d,
  input  logic          i_trk_valid,
  input  logic [MW-1:0] i_trk_miss,
  input  logic [XW-1:0] i_det_x,
  input  logic [YW-1:0] i_det_y,
  input  logic [YW-1:0] i_det_d,
  input  logic          i_matched,
  output logic [XW-1:0] o_trk_x,
  output logic [YW-1:0] o_trk_y,
  output logic [YW-1:0] o_trk_d,
  output logic          o_trk_valid,
  output logic [MW-1:0] o_trk_miss
);
  import tracker_pkg::*;

  localparam int SW = CW + 2;

  // Arithmetic shift floors toward -inf, so the step never overshoots det;
  // the clamp only bites when the raw detection lies off-screen.
  function automatic logic [CW-1:0] smooth(input logic [CW-1:0] trk,
                                           input logic [CW-1:0] det,
                                           input logic [CW-1:0] max_val);
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] sum;
    diff = $signed({2'b00, det}) - $signed({2'b00, trk});
    sum  = $signed({2'b00, trk}) + (diff >>> ALPHA_SHIFT);
    if (sum[SW-1])                        return '0;
    else if (sum > $signed({2'b00, max_val})) return max_val;
    else                                  return sum[CW-1:0];
  endfunction

  logic [MW:0] w_miss_inc;
  assign w_miss_inc = {1'b0, i_trk_miss} + 1'b1;

  // NOTE: every output gets its hold value first so no path through the
  // branches below can leave one unassigned and infer a latch.
  always_comb begin
    o_trk_x     = i_trk_x;
    o_trk_y     = i_trk_y;
    o_trk_d     = i_trk_d;
    o_trk_valid = i_trk_valid;
    o_trk_miss  = i_trk_miss;
    if (i_matched) begin
      o_trk_x    = XW'(smooth(CW'(i_trk_x), CW'(i_det_x), CW'(SCREEN_WIDTH - 1)));
      o_trk_y    = YW'(smooth(CW'(i_trk_y), CW'(i_det_y), CW'(SCREEN_HEIGHT - 1)));
      o_trk_d    = YW'(smooth(CW'(i_trk_d), CW'(i_det_d), CW'(SCREEN_HEIGHT - 1)));
      o_trk_miss = '0;
    end else if (i_trk_valid) begin
      if (w_miss_inc >= (MW+1)'(MAX_MISS)) begin
        o_trk_valid = 1'b0;
        o_trk_miss  = MW'(MAX_MISS);
      end else begin
        o_trk_miss = w_miss_inc[MW-1:0];
      end
    end
  end

endmodule

// File: rtl/target_tracker_wrapper.sv
// Frame-level marker tracker: snapshots detections at frame end, greedily
// matches them to persistent tracks, seeds new tracks, smooths and ages.
module target_tracker_wrapper #(
  parameter int NUM_TARGETS   = 4,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int MATCH_DIST    = 32,
  parameter int ALPHA_SHIFT   = 2,
  parameter int MAX_MISS      = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  target_tracker_wrapper_if.slave bus
);
  import tracker_pkg::*;

  localparam int XW = calc_xw(SCREEN_WIDTH);
  localparam int YW = calc_yw(SCREEN_HEIGHT);
  localparam int IW = calc_iw(NUM_TARGETS);
  localparam int MW = calc_iw(MAX_MISS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_TARGETS - 1);

  state_t r_state, w_next_state;
  logic [IW-1:0] r_ti, r_dj;

  logic [XW-1:0] r_snap_x [NUM_TARGETS];
  logic [YW-1:0] r_snap_y [NUM_TARGETS];
  logic [YW-1:0] r_snap_d [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] r_snap_v;

  logic [NUM_TARGETS-1:0] r_claimed, r_matched, r_seeded;
  logic [IW-1:0] r_match_idx [NUM_TARGETS];
  logic [CW:0]   r_best_dist;
  logic [IW-1:0] r_best_j;
  logic          r_best_found;

  logic [XW-1:0] r_sh_x [NUM_TARGETS];
  logic [YW-1:0] r_sh_y [NUM_TARGETS];
  logic [YW-1:0] r_sh_d [NUM_TARGETS];
  logic [MW-1:0] r_sh_miss [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] r_sh_v;

  logic [NUM_TARGETS*XW-1:0] r_trk_x;
  logic [NUM_TARGETS*YW-1:0] r_trk_y, r_trk_d;
  logic [NUM_TARGETS-1:0]    r_trk_valid;
  logic                      r_frame_done, r_frame_drop;

  logic          w_frame_end;
  logic [CW:0]   w_dist;
  logic          w_cand, w_take, w_fin_found;
  logic [IW-1:0] w_fin_j;
  logic          w_free_found;
  logic [IW-1:0] w_free_idx;
  logic [XW-1:0] w_upd_x;
  logic [YW-1:0] w_upd_y, w_upd_d;
  logic          w_upd_v;
  logic [MW-1:0] w_upd_miss;

  assign w_frame_end = (bus.hcount_in == XW'(SCREEN_WIDTH - 1)) &&
                       (bus.vcount_in == YW'(SCREEN_HEIGHT - 1));

  // Matcher: track r_ti against detection r_dj; the final scan step folds the
  // current candidate into the claim decision.
  assign w_dist = {1'b0, abs_diff(CW'(r_sh_x[r_ti]), CW'(r_snap_x[r_dj]))} +
                  {1'b0, abs_diff(CW'(r_sh_y[r_ti]), CW'(r_snap_y[r_dj]))};
  assign w_cand = r_sh_v[r_ti] && r_snap_v[r_dj] && !r_claimed[r_dj] &&
                  (w_dist <= (CW+1)'(MATCH_DIST));
  assign w_take      = w_cand && (!r_best_found || (w_dist < r_best_dist));
  assign w_fin_found = w_take || r_best_found;
  assign w_fin_j     = w_take ? r_dj : r_best_j;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (!r_sh_v[i] && !r_matched[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  track_slot_update #(
    .XW(XW), .YW(YW), .MW(MW),
    .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .ALPHA_SHIFT(ALPHA_SHIFT), .MAX_MISS(MAX_MISS)
  ) u_slot (
    .i_trk_x    (r_sh_x[r_ti]),
    .i_trk_y    (r_sh_y[r_ti]),
    .i_trk_d    (r_sh_d[r_ti]),
    .i_trk_valid(r_sh_v[r_ti]),
    .i_trk_miss (r_sh_miss[r_ti]),
    .i_det_x    (r_snap_x[r_match_idx[r_ti]]),
    .i_det_y    (r_snap_y[r_match_idx[r_ti]]),
    .i_det_d    (r_snap_d[r_match_idx[r_ti]]),
    .i_matched  (r_matched[r_ti]),
    .o_trk_x    (w_upd_x),
    .o_trk_y    (w_upd_y),
    .o_trk_d    (w_upd_d),
    .o_trk_valid(w_upd_v),
    .o_trk_miss (w_upd_miss)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_frame_end) w_next_state = MATCH;
      MATCH:   if (r_ti == LAST && r_dj == LAST) w_next_state = FILL;
      FILL:    if (r_dj == LAST) w_next_state = UPDATE;
      UPDATE:  if (r_ti == LAST) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: snapshot storage has no reset; every read is qualified by r_snap_v,
  // so leaving it out of reset keeps the array plain enable-only flops.
  always_ff @(posedge clk_in) begin
    if (r_state == IDLE && w_frame_end) begin
      for (int k = 0; k < NUM_TARGETS; k++) begin
        r_snap_x[k] <= bus.det_x_in[k*XW +: XW];
        r_snap_y[k] <= bus.det_y_in[k*YW +: YW];
        r_snap_d[k] <= bus.det_d_in[k*YW +: YW];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ti         <= '0;
      r_dj         <= '0;
      r_snap_v     <= '0;
      r_claimed    <= '0;
      r_matched    <= '0;
      r_seeded     <= '0;
      r_best_dist  <= '0;
      r_best_j     <= '0;
      r_best_found <= 1'b0;
      r_sh_v       <= '0;
      r_trk_x      <= '0;
      r_trk_y      <= '0;
      r_trk_d      <= '0;
      r_trk_valid  <= '0;
      r_frame_done <= 1'b0;
      r_frame_drop <= 1'b0;
      for (int k = 0; k < NUM_TARGETS; k++) begin
        r_match_idx[k] <= '0;
        r_sh_x[k]      <= '0;
        r_sh_y[k]      <= '0;
        r_sh_d[k]      <= '0;
        r_sh_miss[k]   <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      r_frame_drop <= w_frame_end && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_frame_end) begin
            r_snap_v     <= bus.det_valid_in;
            r_claimed    <= '0;
            r_matched    <= '0;
            r_seeded     <= '0;
            r_best_found <= 1'b0;
            r_ti         <= '0;
            r_dj         <= '0;
          end
        end
        MATCH: begin
          if (w_take) begin
            r_best_dist  <= w_dist;
            r_best_j     <= r_dj;
            r_best_found <= 1'b1;
          end
          if (r_dj == LAST) begin
            if (w_fin_found) begin
              r_claimed[w_fin_j]  <= 1'b1;
              r_matched[r_ti]     <= 1'b1;
              r_match_idx[r_ti]   <= w_fin_j;
            end
            r_best_found <= 1'b0;
            r_dj         <= '0;
            r_ti         <= (r_ti == LAST) ? '0 : r_ti + 1'b1;
          end else begin
            r_dj <= r_dj + 1'b1;
          end
        end
        FILL: begin
          if (r_snap_v[r_dj] && !r_claimed[r_dj] && w_free_found) begin
            r_sh_x[w_free_idx]    <= r_snap_x[r_dj];
            r_sh_y[w_free_idx]    <= r_snap_y[r_dj];
            r_sh_d[w_free_idx]    <= r_snap_d[r_dj];
            r_sh_miss[w_free_idx] <= '0;
            r_sh_v[w_free_idx]    <= 1'b1;
            r_seeded[w_free_idx]  <= 1'b1;
          end
          r_dj <= (r_dj == LAST) ? '0 : r_dj + 1'b1;
        end
        UPDATE: begin
          // Freshly seeded slots already hold their exact detection.
          if (!r_seeded[r_ti]) begin
            r_sh_x[r_ti]    <= w_upd_x;
            r_sh_y[r_ti]    <= w_upd_y;
            r_sh_d[r_ti]    <= w_upd_d;
            r_sh_v[r_ti]    <= w_upd_v;
            r_sh_miss[r_ti] <= w_upd_miss;
          end
          r_ti <= (r_ti == LAST) ? '0 : r_ti + 1'b1;
        end
        DONE: begin
          for (int k = 0; k < NUM_TARGETS; k++) begin
            r_trk_x[k*XW +: XW] <= r_sh_x[k];
            r_trk_y[k*YW +: YW] <= r_sh_y[k];
            r_trk_d[k*YW +: YW] <= r_sh_d[k];
          end
          r_trk_valid  <= r_sh_v;
          r_frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.trk_x_out      = r_trk_x;
  assign bus.trk_y_out      = r_trk_y;
  assign bus.trk_d_out      = r_trk_d;
  assign bus.trk_valid_out  = r_trk_valid;
  assign bus.frame_done_out = r_frame_done;
  assign bus.frame_drop_out = r_frame_drop;

endmodule
